// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states and default frame/clock parameters
// used by the master and by the SPI_slave benches.
package spi_pkg;

    localparam int SPI_DATA_WIDTH_DEFAULT  = 8;
    localparam int SPI_HALF_PERIOD_DEFAULT = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: counts 0..HALF_PERIOD-1 and flags the wrap cycle as a tick.
// i_clear holds the count at zero so every FSM state starts a fresh half-period.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = SPI_HALF_PERIOD_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = cnt_width(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt_r;

    // Half-period counter with clear and wrap.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (i_clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign o_tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts one word out on o_mosi MSB first while capturing
// i_miso on each rising SCK edge, framed by CS setup, hold and deselect gaps.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH_DEFAULT,
    parameter int HALF_PERIOD = SPI_HALF_PERIOD_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_miso,
    output logic                  o_sck,
    output logic                  o_mosi,
    output logic                  o_cs,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rx_data
);

    localparam int BIT_CNT_W = cnt_width(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);

    spi_state_e            state_r;
    logic [DATA_WIDTH-1:0] shift_tx_r;
    logic [DATA_WIDTH-1:0] shift_rx_r;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic                  last_bit_r;
    logic                  sck_r;
    logic                  cs_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  tick_s;
    logic                  tick_clr_s;

    // Timer is held cleared while idle; every other state is entered on a wrap.
    always_comb begin
        tick_clr_s = 1'b0;
        if (state_r == IDLE) begin
            tick_clr_s = 1'b1;
        end else begin
            tick_clr_s = 1'b0;
        end
    end

    spi_tick_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (tick_clr_s),
        .o_tick  (tick_s)
    );

    // Frame sequencer with registered pin and handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r    <= IDLE;
            shift_tx_r <= {DATA_WIDTH{1'b0}};
            shift_rx_r <= {DATA_WIDTH{1'b0}};
            rx_data_r  <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= {BIT_CNT_W{1'b0}};
            last_bit_r <= 1'b0;
            sck_r      <= 1'b0;
            cs_r       <= 1'b1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        shift_tx_r <= i_data;
                        shift_rx_r <= {DATA_WIDTH{1'b0}};
                        bit_cnt_r  <= {BIT_CNT_W{1'b0}};
                        last_bit_r <= 1'b0;
                        cs_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        ready_r    <= 1'b0;
                        state_r    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick_s) begin
                        sck_r      <= 1'b1;
                        shift_rx_r <= {shift_rx_r[DATA_WIDTH-2:0], i_miso};
                        state_r    <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick_s) begin
                        sck_r <= 1'b0;
                        // The last bit stays on MOSI through HOLD; otherwise advance.
                        if (bit_cnt_r == BIT_LAST) begin
                            last_bit_r <= 1'b1;
                        end else begin
                            last_bit_r <= 1'b0;
                            shift_tx_r <= {shift_tx_r[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt_r  <= bit_cnt_r + BIT_CNT_W'(1);
                        end
                        state_r <= LOW;
                    end
                end
                LOW: begin
                    if (tick_s) begin
                        if (last_bit_r) begin
                            state_r <= HOLD;
                        end else begin
                            sck_r      <= 1'b1;
                            shift_rx_r <= {shift_rx_r[DATA_WIDTH-2:0], i_miso};
                            state_r    <= HIGH;
                        end
                    end
                end
                HOLD: begin
                    if (tick_s) begin
                        cs_r       <= 1'b1;
                        done_r     <= 1'b1;
                        rx_data_r  <= shift_rx_r;
                        shift_tx_r <= {DATA_WIDTH{1'b0}};
                        state_r    <= GAP;
                    end
                end
                GAP: begin
                    if (tick_s) begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    sck_r      <= 1'b0;
                    cs_r       <= 1'b1;
                    shift_tx_r <= {DATA_WIDTH{1'b0}};
                    ready_r    <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign o_sck     = sck_r;
    assign o_mosi    = shift_tx_r[DATA_WIDTH-1];
    assign o_cs      = cs_r;
    assign o_ready   = ready_r;
    assign o_busy    = busy_r;
    assign o_done    = done_r;
    assign o_rx_data = rx_data_r;

endmodule
